rect_fill_writer: RTL and testbench

Pixel-stream producer for the SRAM frame-buffer controller's program-side write port. It accepts one rectangle-fill command (origin, size, RGB565 colour) and emits one pixel write per accepted handshake in row-major order on program_x / program_y / program_data. It sits between game logic (sprite/box renderers) and the SRAM controller, replacing ad-hoc coordinate counters in the top level.

---
 rtl/rect_fill_writer_if.sv | 28 ++
 rtl/rect_fill_writer.sv | 145 ++++++++++++++
 tb/tb_rect_fill_writer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_fill_writer_if.sv
// Command and pixel-write bundle for rect_fill_writer.
// master: the fill writer (drives status and pixel writes).
// slave:  the command source / SRAM-controller side.
interface rect_fill_writer_if;
  logic        start;
  logic [9:0]  cmd_x;
  logic [9:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [9:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        busy;
  logic        done;
  logic        program_valid;
  logic        program_ready;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;

  modport master (
    input  start, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, program_ready,
    output busy, done, program_valid, program_x, program_y, program_data
  );

  modport slave (
    output start, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, program_ready,
    input  busy, done, program_valid, program_x, program_y, program_data
  );
endinterface

// File: rtl/rect_fill_writer.sv
// Rectangle-fill pixel producer: one command in, w*h row-major pixel writes out.
// Optional feature macro: RECT_FILL_CLIP_EN clips the rectangle to SCREEN_W x SCREEN_H
// at accept time; without it coordinates wrap modulo 1024.
module rect_fill_writer #(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input logic                clk,
  input logic                reset_n,
  rect_fill_writer_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  x0_q, x0_d;
  logic [9:0]  y0_q, y0_d;
  logic [9:0]  w_q, w_d;
  logic [9:0]  h_q, h_d;
  logic [15:0] color_q, color_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;

  logic [9:0]  eff_w, eff_h;
  logic        accept, hs, last_col, last_row;

  // Coordinates are 10 bits wide, so a larger screen cannot be addressed.
  if (SCREEN_W > 1023 || SCREEN_H > 1023) begin : g_screen_too_big
    $error("rect_fill_writer: SCREEN_W/SCREEN_H must fit 10-bit coordinates");
  end

`ifdef RECT_FILL_CLIP_EN
  localparam logic [10:0] ScreenW = 11'(SCREEN_W);
  localparam logic [10:0] ScreenH = 11'(SCREEN_H);
  logic [10:0] room_w, room_h;

  // Clip size to the visible area; an origin off-screen yields an empty rectangle.
  always_comb begin
    room_w = ScreenW - {1'b0, bus_io.cmd_x};
    room_h = ScreenH - {1'b0, bus_io.cmd_y};
    if ({1'b0, bus_io.cmd_x} >= ScreenW)     eff_w = '0;
    else if ({1'b0, bus_io.cmd_w} < room_w)  eff_w = bus_io.cmd_w;
    else                                     eff_w = room_w[9:0];
    if ({1'b0, bus_io.cmd_y} >= ScreenH)     eff_h = '0;
    else if ({1'b0, bus_io.cmd_h} < room_h)  eff_h = bus_io.cmd_h;
    else                                     eff_h = room_h[9:0];
  end
`else
  // No clipping: size taken as given, coordinates wrap.
  always_comb begin
    eff_w = bus_io.cmd_w;
    eff_h = bus_io.cmd_h;
  end
`endif

  // Handshake and end-of-row / end-of-rectangle decode.
  always_comb begin
    accept   = (state_q == StIdle) && bus_io.start;
    hs       = (state_q == StRun) && bus_io.program_ready;
    last_col = (col_q == w_q - 10'd1);
    last_row = (row_q == h_q - 10'd1);
  end

  // State and datapath registers; reset abandons any rectangle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = (eff_w == '0 || eff_h == '0) ? StDone : StRun;
        end
      end
      StRun:   if (hs && last_col && last_row) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command latch and row-major col/row stepping on each handshake.
  always_comb begin
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      x0_d    = bus_io.cmd_x;
      y0_d    = bus_io.cmd_y;
      w_d     = eff_w;
      h_d     = eff_h;
      color_d = bus_io.cmd_color;
      col_d   = '0;
      row_d   = '0;
    end else if (hs) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  // Outputs; pixel fields are zeroed outside RUN so reset forces them low.
  // busy covers the accept cycle too, hence the start term (gated by reset).
  always_comb begin
    bus_io.program_valid = (state_q == StRun);
    bus_io.program_x     = '0;
    bus_io.program_y     = '0;
    bus_io.program_data  = '0;
    if (state_q == StRun) begin
      bus_io.program_x    = x0_q + col_q;
      bus_io.program_y    = y0_q + row_q;
      bus_io.program_data = color_q;
    end
    bus_io.done = (state_q == StDone);
    bus_io.busy = reset_n && ((state_q != StIdle) || bus_io.start);
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer (directed commands, pixel-list model).
module tb_rect_fill_writer;

  typedef struct {
    int x;
    int y;
    int d;
  } pix_t;

  logic clk;
  logic reset_n;
  int   cyc;

  rect_fill_writer_if bus ();

  rect_fill_writer #(
    .SCREEN_W(640),
    .SCREEN_H(480)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  pix_t exp_q[$];
  int   hs_x[$], hs_y[$], hs_d[$], hs_c[$];
  bit   active, done_due, chk_en, bp_mode;
  bit   m_acc, m_hs, m_ev;
  pix_t m_p;
  int   n_vec, n_bad;
  int   busy_cnt, valid_cnt, done_cnt, done_cyc, accept_cyc, vcnt;

  initial begin
    clk = 0;
    cyc = 0;
    forever begin
      #5 clk = 1;
      cyc++;
      #5 clk = 0;
    end
  end

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endfunction

  // Model: a command becomes the full list of pixels it must produce.
  task automatic model_accept(input int x, input int y, input int w, input int h, input int c);
    int ew, eh;
    ew = w;
    eh = h;
`ifdef RECT_FILL_CLIP_EN
    ew = (x >= 640) ? 0 : ((w < 640 - x) ? w : 640 - x);
    eh = (y >= 480) ? 0 : ((h < 480 - y) ? h : 480 - y);
`endif
    for (int r = 0; r < eh; r++) begin
      for (int k = 0; k < ew; k++) begin
        exp_q.push_back('{x: (x + k) % 1024, y: (y + r) % 1024, d: c});
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      active   = 0;
      done_due = 0;
    end else if (chk_en) begin
      m_acc = !active && bus.start;
      m_ev  = active && !done_due && (exp_q.size() > 0);
      check("valid", int'(bus.program_valid), int'(m_ev));
      check("busy", int'(bus.busy), int'(active || m_acc));
      check("done", int'(bus.done), int'(done_due));
      if (bus.program_valid && exp_q.size() > 0) begin
        m_p = exp_q[0];
        check("pix_x", int'(bus.program_x), m_p.x);
        check("pix_y", int'(bus.program_y), m_p.y);
        check("pix_data", int'(bus.program_data), m_p.d);
      end
      if (bus.busy) busy_cnt++;
      if (bus.program_valid) valid_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.program_valid && bus.program_ready) begin
        hs_x.push_back(int'(bus.program_x));
        hs_y.push_back(int'(bus.program_y));
        hs_d.push_back(int'(bus.program_data));
        hs_c.push_back(cyc);
      end
      m_hs = m_ev && bus.program_ready;
      if (done_due) begin
        done_due = 0;
        active   = 0;
      end else if (m_hs) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_due = 1;
      end
      if (m_acc) begin
        model_accept(int'(bus.cmd_x), int'(bus.cmd_y), int'(bus.cmd_w), int'(bus.cmd_h),
                     int'(bus.cmd_color));
        active     = 1;
        accept_cyc = cyc;
        if (exp_q.size() == 0) done_due = 1;
      end
    end
  end

  // Ready driver: in backpressure mode, stall the 1st and 3rd valid cycles.
  initial begin
    bus.program_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && bus.program_valid) begin
        vcnt++;
        bus.program_ready = !(vcnt == 1 || vcnt == 3);
      end else begin
        bus.program_ready = 1;
      end
    end
  end

  task automatic clear_stats();
    hs_x.delete();
    hs_y.delete();
    hs_d.delete();
    hs_c.delete();
    busy_cnt  = 0;
    valid_cnt = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    vcnt      = 0;
  endtask

  task automatic send(input int x, input int y, input int w, input int h, input int c);
    @(posedge clk);
    #1;
    bus.cmd_x     = 10'(x);
    bus.cmd_y     = 10'(y);
    bus.cmd_w     = 10'(w);
    bus.cmd_h     = 10'(h);
    bus.cmd_color = 16'(c);
    bus.start     = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
  endtask

  task automatic wait_done(input int limit);
    int c0;
    bit seen;
    c0   = done_cnt;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (done_cnt > c0);
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, int'(bus.program_valid), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_x"}, int'(bus.program_x), 0);
    check({tag, "_y"}, int'(bus.program_y), 0);
    check({tag, "_data"}, int'(bus.program_data), 0);
  endtask

  initial begin
    bit seen;
    n_vec         = 0;
    n_bad         = 0;
    reset_n       = 0;
    chk_en        = 0;
    bp_mode       = 0;
    bus.start     = 0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset_n = 1;
    chk_en  = 1;

    // Basic 2x2 fill.
    clear_stats();
    send(10, 20, 2, 2, 16'hF800);
    wait_done(20);
    check("b2_count", hs_x.size(), 4);
    if (hs_x.size() == 4) begin
      check("b2_x0", hs_x[0], 10);
      check("b2_y0", hs_y[0], 20);
      check("b2_x1", hs_x[1], 11);
      check("b2_y1", hs_y[1], 20);
      check("b2_x2", hs_x[2], 10);
      check("b2_y2", hs_y[2], 21);
      check("b2_x3", hs_x[3], 11);
      check("b2_y3", hs_y[3], 21);
      check("b2_data", hs_d[3], 16'hF800);
      check("b2_consec", hs_c[3] - hs_c[0], 3);
      check("b2_first", hs_c[0], accept_cyc + 1);
      check("b2_done_cyc", done_cyc, hs_c[3] + 1);
    end
    check("b2_busy_cycles", busy_cnt, 6);

    // Backpressure 3x1 at origin.
    clear_stats();
    bp_mode = 1;
    send(0, 0, 3, 1, 16'h07E0);
    wait_done(20);
    bp_mode = 0;
    check("bp_count", hs_x.size(), 3);
    check("bp_valid_cycles", valid_cnt, 5);
    if (hs_x.size() == 3) begin
      check("bp_x0", hs_x[0], 0);
      check("bp_x1", hs_x[1], 1);
      check("bp_x2", hs_x[2], 2);
      check("bp_hs0_cyc", hs_c[0], accept_cyc + 2);
      check("bp_hs2_cyc", hs_c[2], accept_cyc + 5);
      check("bp_done_cyc", done_cyc, hs_c[2] + 1);
    end

    // Zero-size command.
    clear_stats();
    send(5, 5, 0, 5, 16'h1234);
    wait_done(10);
    check("z_valid_cycles", valid_cnt, 0);
    check("z_done_cyc", done_cyc, accept_cyc + 1);
    check("z_busy_cycles", busy_cnt, 2);

    // Clip / wrap corner.
    clear_stats();
    send(638, 479, 4, 3, 16'hABCD);
    wait_done(40);
`ifdef RECT_FILL_CLIP_EN
    check("clip_count", hs_x.size(), 2);
    if (hs_x.size() == 2) begin
      check("clip_x0", hs_x[0], 638);
      check("clip_x1", hs_x[1], 639);
      check("clip_y1", hs_y[1], 479);
    end
`else
    check("wrap_count", hs_x.size(), 12);
    if (hs_x.size() == 12) begin
      check("wrap_x2", hs_x[2], 640);
      check("wrap_x3", hs_x[3], 641);
      check("wrap_y11", hs_y[11], 481);
    end
`endif

    // Reset in the middle of a 10x10 fill.
    clear_stats();
    send(50, 60, 10, 10, 16'h5555);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (hs_x.size() >= 7);
    end
    if (!seen) check("rst_wait_timeout", 0, 1);
    @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    check_zero_outputs("midrst");
    check("midrst_hs_count", hs_x.size(), 7);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1;
    clear_stats();
    send(5, 6, 1, 1, 16'h0F0F);
    wait_done(10);
    check("post_rst_count", hs_x.size(), 1);
    if (hs_x.size() == 1) begin
      check("post_rst_x", hs_x[0], 5);
      check("post_rst_y", hs_y[0], 6);
    end

    // Start while busy is dropped.
    clear_stats();
    send(100, 200, 3, 2, 16'h001F);
    @(posedge clk);
    #1;
    bus.cmd_x     = 10'd0;
    bus.cmd_y     = 10'd0;
    bus.cmd_w     = 10'd1;
    bus.cmd_h     = 10'd1;
    bus.cmd_color = 16'hF800;
    bus.start     = 1;
    @(posedge clk);
    #1;
    bus.start = 0;
    wait_done(30);
    repeat (5) @(posedge clk);
    #1;
    check("sb_count", hs_x.size(), 6);
    check("sb_done_pulses", done_cnt, 1);
    for (int i = 0; i < hs_d.size(); i++) check("sb_color", hs_d[i], 16'h001F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case a wait somehow escapes its bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
